// File: rtl/prefix_adder.sv
// 8-bit Kogge-Stone adder with registered sum and carry-out.
// Internal prefix signals are LSB-indexed (bit k has weight 2^k); ports use [0:7] MSB-first.
module ks_black (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);
  assign g = gh | (ph & gl);
  assign p = ph & pl;
endmodule

module ks_grey (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  output logic g
);
  assign g = gh | (ph & gl);
endmodule

module prefix_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:7] a,
  input  logic [0:7] b,
  output logic [0:7] o,
  output logic       cout
);
  logic [7:0] g0, p0, g1, g2, g3, c;
  logic [7:2] p1;
  logic [7:4] p2;
  logic [0:7] sum;

  genvar k;
  generate
    for (k = 0; k < 8; k++) begin : g_pre
      assign g0[k] = a[7-k] & b[7-k];
      assign p0[k] = a[7-k] ^ b[7-k];
    end

    // Span 1: a group reaching bit 0 never needs its P again, so it gets a grey cell.
    assign g1[0] = g0[0];
    for (k = 1; k < 8; k++) begin : g_l1
      if (k < 2) begin : g_grey
        ks_grey u_cell (.gh(g0[k]), .ph(p0[k]), .gl(g0[k-1]), .g(g1[k]));
      end else begin : g_blk
        ks_black u_cell (.gh(g0[k]), .ph(p0[k]), .gl(g0[k-1]), .pl(p0[k-1]),
                         .g(g1[k]), .p(p1[k]));
      end
    end

    // Span 2
    assign g2[1:0] = g1[1:0];
    for (k = 2; k < 8; k++) begin : g_l2
      if (k < 4) begin : g_grey
        ks_grey u_cell (.gh(g1[k]), .ph(p1[k]), .gl(g1[k-2]), .g(g2[k]));
      end else begin : g_blk
        ks_black u_cell (.gh(g1[k]), .ph(p1[k]), .gl(g1[k-2]), .pl(p1[k-2]),
                         .g(g2[k]), .p(p2[k]));
      end
    end

    // Span 4: every output now spans down to bit 0.
    assign g3[3:0] = g2[3:0];
    for (k = 4; k < 8; k++) begin : g_l3
      ks_grey u_cell (.gh(g2[k]), .ph(p2[k]), .gl(g2[k-4]), .g(g3[k]));
    end

    assign c[0] = 1'b0;
    for (k = 1; k < 8; k++) begin : g_carry
      assign c[k] = g3[k-1];
    end

    for (k = 0; k < 8; k++) begin : g_sum
      assign sum[7-k] = p0[k] ^ c[k];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o    <= '0;
      cout <= 1'b0;
    end else begin
      o    <= sum;
      cout <= g3[7];
    end
  end
endmodule

// File: tb/tb_prefix_adder.sv
// Self-checking bench for prefix_adder: directed cases, exhaustive sweep, mid-stream reset.
module tb_prefix_adder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:7] a, b;
  logic [0:7] o;
  logic       cout;
  int         errs = 0;
  int         nchk = 0;

  prefix_adder dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .o(o), .cout(cout));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got cout=%0b o=%0d, expected cout=%0b o=%0d",
               tag, got[8], got[7:0], exp[8], exp[7:0]);
    end
  endtask

  // Drive operands, clock once, then compare against the arithmetic reference.
  task automatic step(input string tag, input int av, input int bv, input logic rst);
    int ref_v;
    a     = av[7:0];
    b     = bv[7:0];
    rst_n = rst;
    @(posedge clk);
    #1;
    ref_v = rst ? (av + bv) : 0;
    chk(tag, {cout, o}, ref_v[8:0]);
  endtask

  initial begin
    a = 8'hFF; b = 8'h01; rst_n = 1'b0;
    @(negedge clk);
    step("reset1", 8'hFF, 8'h01, 1'b0);
    step("reset2", 8'hFF, 8'h01, 1'b0);

    step("zero_a",   8'h00, 65,    1'b1);
    step("multi",    100,   24,    1'b1);
    step("all_prop", 85,    170,   1'b1);
    step("ff_01",    8'hFF, 8'h01, 1'b1);
    step("80_80",    8'h80, 8'h80, 1'b1);
    step("ff_ff",    8'hFF, 8'hFF, 1'b1);
    step("zero",     0,     0,     1'b1);

    // A reset glitch between edges must not reach the register.
    a = 8'd200; b = 8'd100;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midcycle_rst", {cout, o}, 9'd300);

    // Operands changing mid-cycle: only the edge value counts.
    a = 8'd1; b = 8'd2;
    #2 a = 8'd150; b = 8'd150;
    @(posedge clk);
    #1;
    chk("midcycle_op", {cout, o}, 9'd300);

    for (int i = 0; i < 65536; i++) begin
      if (i == 30000) begin
        step("stream_rst", i >> 8, i & 255, 1'b0);
      end
      step("sweep", i >> 8, i & 255, 1'b1);
    end

    for (int j = 0; j < 200; j++) begin
      int x, y;
      x = $urandom_range(255);
      y = $urandom_range(255);
      step("rand", x, y, ($urandom_range(15) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/prefix_adder.md
# prefix_adder

8-bit parallel-prefix (Kogge-Stone) adder with registered outputs. Adds two unsigned 8-bit operands and presents the sum, modulo 256, plus a carry-out one clock after the operands are sampled. It is a leaf arithmetic block for datapaths that need log-depth carry computation rather than a ripple chain.

## Interface

Parameters:
- none. Width is fixed at 8 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- a  input  [0:7]  operand A, unsigned; index 0 is the MSB, index 7 is the LSB
- b  input  [0:7]  operand B, unsigned; same bit ordering as a
- o  output  [0:7]  registered sum (a + b) mod 256; index 0 is the MSB
- cout  output  1  registered carry-out of the MSB position

## Operation

- Bit weights:
  - Vectors use ascending [0:7] declaration.
  - Bit i carries weight 2^(7-i).
  - Positional instantiation with 8'bxxxxxxxx literals gives the usual numeric value.
- Pre-processing, per bit:
  - g_i = a_i & b_i
  - p_i = a_i ^ b_i
- Prefix network:
  - Three Kogge-Stone levels, with spans 1, 2 and 4 bit positions toward the LSB.
  - Black cell: G = Gh | (Ph & Gl), P = Ph & Pl.
  - Grey cell: G only, used where the P output is not needed.
  - Positions with no partner at a level pass G/P through unchanged.
- Carry-in is fixed at 0.
  - Carry into the LSB (index 7) is 0.
  - Carry into index i is the group G spanning from the LSB up to the position below i.
- Sum: s_i = p_i ^ carry_into_i.
- Carry-out: cout = group G spanning all 8 bits.
- Network depth:
  - The network must be purely combinational and log-depth.
  - A ripple chain or a behavioural a+b is not acceptable for the sum path.
  - The result must still match a+b bit-exactly.
- Register stage:
  - On each rising clk with rst_n=1, o <= s and cout <= carry-out.
  - Inputs are not registered.
- Overflow wraps modulo 256; cout=1 flags it.
- There is no enable and no valid signal. A new result is computed every cycle.

## Timing

- Latency: 1 cycle.
  - a/b sampled at rising edge N appear on o/cout after edge N and hold until edge N+1.
- Throughput: one addition per clock.
- Reset:
  - rst_n=0 at a rising edge forces o=8'b00000000 and cout=0 at that edge.
  - Reset is synchronous only. Deasserting or asserting rst_n between edges has no effect until the next edge.
  - Reset wins over a concurrent operand change at the same edge.
  - At the first edge with rst_n=1 after reset, the current a+b is captured; there are no dead cycles.
- Before the first clock edge, outputs are undefined. Benches must apply reset first.
- Operand changes mid-cycle are allowed; only the values at the edge matter.
- Combinational path a/b -> register D input: 1 pre-process level + 3 prefix levels + 1 XOR level.

## Test plan

- Reset: hold rst_n=0 for 2 edges with a=8'hFF, b=8'h01 -> o=8'b00000000, cout=0.
- Zero operand, basic latency: after reset, a=8'b00000000, b=8'b01000001 (65) -> one edge later o=8'b01000001 (65), cout=0.
- Carries through multiple positions: a=8'b01100100 (100), b=8'b00011000 (24) -> o=8'b01111100 (124), cout=0.
- All-propagate, no carry: a=8'b01010101 (85), b=8'b10101010 (170) -> o=8'b11111111 (255), cout=0.
- Full carry chain and overflow: a=8'hFF, b=8'h01 -> o=8'h00, cout=1; a=8'h80, b=8'h80 -> o=8'h00, cout=1; a=8'hFF, b=8'hFF -> o=8'hFE, cout=1.
- Exhaustive and streaming:
  - Sweep all 65,536 (a,b) pairs, one per clock; compare o/cout against a reference (a+b) delayed by one cycle.
  - Assert rst_n=0 for one edge mid-stream -> that cycle's output is 0, and the next edge resumes correct sums.
